// File: rtl/prog_loader_pkg.sv
// ============================================================================
// prog_loader_pkg : loader state encoding and chunk-count helper
// Rev 1.0
// ============================================================================
`default_nettype none

package prog_loader_pkg;

  typedef enum logic [1:0] {
    LD_LOAD  = 2'd0,
    LD_CHECK = 2'd1,
    LD_RUN   = 2'd2
  } ld_state_e;

  function automatic int nchunk(input int instr_w, input int chunk_w);
    return (instr_w + chunk_w - 1) / chunk_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/prog_loader_if.sv
// ============================================================================
// prog_loader_if : pad-side chunk handshake and CPU instruction read port
// Rev 1.0
// ============================================================================
`default_nettype none

interface prog_loader_if #(
  parameter int INSTR_W = 12,
  parameter int CHUNK_W = 6,
  parameter int DEPTH   = 8
);
  localparam int AW = $clog2(DEPTH);

  logic               in_valid;
  logic [CHUNK_W-1:0] in_chunk;
  logic               in_ready;
  logic               reload;
  logic [AW-1:0]      rd_addr;
  logic [INSTR_W-1:0] rd_data;
  logic               done;
  logic               csum_err;

  modport master (
    output in_valid, in_chunk, reload, rd_addr,
    input  in_ready, rd_data, done, csum_err
  );

  modport slave (
    input  in_valid, in_chunk, reload, rd_addr,
    output in_ready, rd_data, done, csum_err
  );

endinterface

`default_nettype wire

// File: rtl/prog_loader_mem.sv
// ============================================================================
// prog_mem : DEPTH x INSTR_W instruction store, sync clear, async read
// Rev 1.0
// ============================================================================
`default_nettype none

module prog_mem #(
  parameter int INSTR_W = 12,
  parameter int DEPTH   = 8
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     we,
  input  wire logic [$clog2(DEPTH)-1:0] wr_addr,
  input  wire logic [INSTR_W-1:0]       wr_data,
  input  wire logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic      [INSTR_W-1:0]       rd_data
);
  localparam int AW = $clog2(DEPTH);

  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [INSTR_W-1:0] mem_d [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = (we && (wr_addr == AW'(i))) ? wr_data : mem_q[i];
    end
  end

  // Read the registered array so a same-cycle write returns the old word
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_addr == AW'(i)) rd_data = mem_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule

`default_nettype wire

// File: rtl/prog_loader.sv
// ============================================================================
// prog_loader : assembles chunked instruction words into prog_mem, then done
// Option macro PROG_LOADER_CSUM_EN adds a trailing XOR checksum chunk gate.
// Rev 1.0
// ============================================================================
`default_nettype none

module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int INSTR_W = 12,
  parameter int CHUNK_W = 6,
  parameter int DEPTH   = 8
) (
  input wire logic   clk,
  input wire logic   rst,
  prog_loader_if.slave bus
);
  localparam int            AW         = $clog2(DEPTH);
  localparam int            NCHUNK     = nchunk(INSTR_W, CHUNK_W);
  localparam int            CW         = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);
  localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);

  ld_state_e          state_q, state_d;
  logic [CW-1:0]      chunk_cnt_q, chunk_cnt_d;
  logic [AW-1:0]      wr_addr_q, wr_addr_d;
  logic [INSTR_W-1:0] asm_q, asm_d;
  logic               done_q, done_d;
  logic               in_ready_q, in_ready_d;
  logic               accept;
  logic               mem_we;
`ifdef PROG_LOADER_CSUM_EN
  logic [CHUNK_W-1:0] csum_q, csum_d;
  logic               csum_err_q, csum_err_d;
`endif

  assign accept = bus.in_valid & in_ready_q;

  always_comb begin
    state_d     = state_q;
    chunk_cnt_d = chunk_cnt_q;
    wr_addr_d   = wr_addr_q;
    asm_d       = asm_q;
    mem_we      = 1'b0;
`ifdef PROG_LOADER_CSUM_EN
    csum_d      = csum_q;
    csum_err_d  = csum_err_q;
`endif
    if (bus.reload) begin
      state_d     = LD_LOAD;
      chunk_cnt_d = '0;
      wr_addr_d   = '0;
`ifdef PROG_LOADER_CSUM_EN
      csum_d      = '0;
`endif
    end else begin
      case (state_q)
        LD_LOAD: begin
          if (accept) begin
            // Bits beyond INSTR_W-1 in the final chunk simply have no slot
            for (int b = 0; b < INSTR_W; b++) begin
              if (chunk_cnt_q == CW'(b / CHUNK_W)) asm_d[b] = bus.in_chunk[b % CHUNK_W];
            end
`ifdef PROG_LOADER_CSUM_EN
            csum_d = csum_q ^ bus.in_chunk;
`endif
            if (chunk_cnt_q == LAST_CHUNK) begin
              mem_we      = 1'b1;
              chunk_cnt_d = '0;
              if (wr_addr_q == LAST_ADDR) begin
                wr_addr_d = '0;
`ifdef PROG_LOADER_CSUM_EN
                state_d   = LD_CHECK;
`else
                state_d   = LD_RUN;
`endif
              end else begin
                wr_addr_d = wr_addr_q + AW'(1);
              end
            end else begin
              chunk_cnt_d = chunk_cnt_q + CW'(1);
            end
          end
        end
`ifdef PROG_LOADER_CSUM_EN
        LD_CHECK: begin
          if (accept) begin
            if (bus.in_chunk == csum_q) begin
              state_d    = LD_RUN;
              csum_err_d = 1'b0;
            end else begin
              state_d     = LD_LOAD;
              csum_err_d  = 1'b1;
              chunk_cnt_d = '0;
              wr_addr_d   = '0;
              csum_d      = '0;
            end
          end
        end
`endif
        LD_RUN:  ;
        default: state_d = LD_LOAD;
      endcase
    end
    done_d     = (state_d == LD_RUN);
    in_ready_d = (state_d != LD_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LD_LOAD;
      chunk_cnt_q <= '0;
      wr_addr_q   <= '0;
      asm_q       <= '0;
      done_q      <= 1'b0;
      in_ready_q  <= 1'b1;
`ifdef PROG_LOADER_CSUM_EN
      csum_q      <= '0;
      csum_err_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      chunk_cnt_q <= chunk_cnt_d;
      wr_addr_q   <= wr_addr_d;
      asm_q       <= asm_d;
      done_q      <= done_d;
      in_ready_q  <= in_ready_d;
`ifdef PROG_LOADER_CSUM_EN
      csum_q      <= csum_d;
      csum_err_q  <= csum_err_d;
`endif
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.done     = done_q;
`ifdef PROG_LOADER_CSUM_EN
  assign bus.csum_err = csum_err_q;
`else
  assign bus.csum_err = 1'b0;
`endif

  prog_mem #(
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we      (mem_we),
    .wr_addr (wr_addr_q),
    .wr_data (asm_d),
    .rd_addr (bus.rd_addr),
    .rd_data (bus.rd_data)
  );

endmodule

`default_nettype wire
